// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencing FSM between the execute issue logic and an iterative mul/div core.
// Captures one request, loads and steps the core, then holds the result until writeback takes it.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_word,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic [63:0] md_A,
  output logic [63:0] md_B,
  output logic        md_sign,
  output logic        md_mul_div,
  output logic        md_width,
  output logic [6:0]  md_cnt,
  output logic        md_reseted,
  input  logic [63:0] md_out,
  input  logic [63:0] md_r,
  input  logic        md_finished
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_REM  = 3'd3,
    OP_REMU = 3'd4
  } op_e;

  localparam logic [6:0] CNT_MAX = 7'd127;

  state_e      r_state;
  state_e      w_next;
  logic [2:0]  r_op;
  logic        r_word;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [4:0]  r_rd;
  logic [63:0] r_result;
  logic [6:0]  r_cnt;

  logic        w_accept;
  logic        w_finish;
  logic        w_count;
  logic        w_use_rem;
  logic [63:0] w_sel;
  logic [63:0] w_result;

  assign w_accept = req_valid && req_ready;
  // A flush in the finishing cycle wins, so the core result is never captured.
  assign w_finish = (r_state == S_RUN) && md_finished && !flush;
  assign w_count  = ((r_state == S_LOAD) || ((r_state == S_RUN) && !md_finished))
                    && (r_cnt != CNT_MAX);

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    md_reseted = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) w_next = S_LOAD;
      end
      S_LOAD: w_next = S_RUN;
      S_RUN: begin
        md_reseted = 1'b1;
        if (md_finished) w_next = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= 3'd0;
      r_word   <= 1'b0;
      r_a      <= 64'd0;
      r_b      <= 64'd0;
      r_rd     <= 5'd0;
      r_result <= 64'd0;
      r_cnt    <= 7'd0;
    end else begin
      if (w_accept) begin
        r_op   <= req_op;
        r_word <= req_word;
        r_a    <= req_a;
        r_b    <= req_b;
        r_rd   <= req_rd;
        r_cnt  <= 7'd0;
      end else if (w_count) begin
        r_cnt  <= r_cnt + 7'd1;
      end
      if (w_finish) r_result <= w_result;
    end
  end

  // Codes 5-7 fall through every decode below and therefore behave as MUL.
  assign md_mul_div = (r_op == OP_DIV) || (r_op == OP_DIVU) ||
                      (r_op == OP_REM) || (r_op == OP_REMU);
  assign md_sign    = (r_op == OP_DIV) || (r_op == OP_REM);
  assign md_width   = r_word;
  assign w_use_rem  = (r_op == OP_REM) || (r_op == OP_REMU);

  // Word operands sit in the upper half so the core's 64-bit datapath sees their sign bit.
  assign md_A = r_word ? {r_a[31:0], 32'd0} : r_a;
  assign md_B = r_word ? {r_b[31:0], 32'd0} : r_b;

  assign w_sel    = w_use_rem ? md_r : md_out;
  assign w_result = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

  assign md_cnt    = r_cnt;
  assign resp_data = r_result;
  assign resp_rd   = r_rd;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a behavioural mul/div core answers the controller,
// and a scoreboard of expected responses is checked as each response appears.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_word;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;
  logic [63:0] md_A;
  logic [63:0] md_B;
  logic        md_sign;
  logic        md_mul_div;
  logic        md_width;
  logic [6:0]  md_cnt;
  logic        md_reseted;
  logic [63:0] md_out;
  logic [63:0] md_r;
  logic        md_finished;

  logic        stall;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_word   (req_word),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rd     (req_rd),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .md_A       (md_A),
    .md_B       (md_B),
    .md_sign    (md_sign),
    .md_mul_div (md_mul_div),
    .md_width   (md_width),
    .md_cnt     (md_cnt),
    .md_reseted (md_reseted),
    .md_out     (md_out),
    .md_r       (md_r),
    .md_finished(md_finished)
  );

  // Behavioural core: finishes on iteration 65 (64-bit) or 33 (word), or at once on a
  // zero divisor; word results carry junk in the upper half to expose missing sign extension.
  logic [31:0] a32, b32, p32, q32, r32;
  logic [63:0] p64, q64, r64;
  always_comb begin
    a32 = md_A[63:32];
    b32 = md_B[63:32];
    p32 = a32 * b32;
    p64 = md_A * md_B;
    if (b32 == 32'd0) begin
      q32 = '1;
      r32 = a32;
    end else if (md_sign) begin
      q32 = $signed(a32) / $signed(b32);
      r32 = $signed(a32) % $signed(b32);
    end else begin
      q32 = a32 / b32;
      r32 = a32 % b32;
    end
    if (md_B == 64'd0) begin
      q64 = '1;
      r64 = md_A;
    end else if (md_sign) begin
      q64 = $signed(md_A) / $signed(md_B);
      r64 = $signed(md_A) % $signed(md_B);
    end else begin
      q64 = md_A / md_B;
      r64 = md_A % md_B;
    end
    if (md_width) begin
      md_out = {32'hDEAD_BEEF, md_mul_div ? q32 : p32};
      md_r   = {32'hDEAD_BEEF, r32};
    end else begin
      md_out = md_mul_div ? q64 : p64;
      md_r   = r64;
    end
    md_finished = md_reseted && !stall &&
                  ((md_mul_div && (md_width ? (b32 == 32'd0) : (md_B == 64'd0))) ||
                   (md_cnt == (md_width ? 7'd33 : 7'd65)));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request through the handshake and checks the LOAD cycle that follows.
  task automatic do_req(input logic [2:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp_data, input int exp_lat, input bit expect_resp);
    exp_t e;
    @(negedge clk);
    req_op = op; req_word = word; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    #1 check("req_ready_idle", req_ready, 1);
    if (expect_resp) begin
      e.data = exp_data; e.rd = rd; e.lat = exp_lat;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("load_reseted", md_reseted, 0);
    check("load_cnt", md_cnt, 0);
    check("md_A", md_A, word ? {a[31:0], 32'd0} : a);
    check("md_B", md_B, word ? {b[31:0], 32'd0} : b);
    check("md_mul_div", md_mul_div, op inside {3'd1, 3'd2, 3'd3, 3'd4});
    check("md_sign", md_sign, (op == 3'd1) || (op == 3'd3));
    check("md_width", md_width, word);
  endtask

  // Called in the LOAD cycle: waits for the response, compares it with the scoreboard head,
  // optionally stalls writeback, then consumes it (optionally together with a flush).
  task automatic collect(input int hold, input bit with_flush);
    exp_t        e;
    int          cyc;
    logic [63:0] d0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      #1;
    end
    check("sb_size", sb.size(), 1);
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.data = '0; e.rd = '0; e.lat = 0; end
    check("latency", cyc, e.lat);
    check("resp_data", resp_data, e.data);
    check("resp_rd", resp_rd, e.rd);
    check("cnt_held", md_cnt, e.lat - 2);
    d0 = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, d0);
    end
    resp_ready = 1'b1;
    flush      = with_flush;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    flush      = 1'b0;
    #1;
    check("after_xfer_valid", resp_valid, 0);
    check("after_xfer_ready", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_word = 1'b0; req_a = '0; req_b = '0;
    req_rd = '0; flush = 1'b0; resp_ready = 1'b0; stall = 1'b0;

    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_cnt", md_cnt, 0);
    check("rst_reseted", md_reseted, 0);
    check("rst_md_A", md_A, 0);
    check("rst_md_B", md_B, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_rd", resp_rd, 0);
    @(negedge clk);
    reset = 1'b0;

    // Main function across ops, widths and trivial early finish.
    do_req(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 67, 1'b1);
    collect(0, 1'b0);
    do_req(3'd2, 1'b1, 64'd100, 64'd7, 5'd9, 64'd14, 35, 1'b1);
    collect(10, 1'b0);
    do_req(3'd4, 1'b1, 64'd100, 64'd7, 5'd10, 64'd2, 35, 1'b1);
    collect(0, 1'b0);
    do_req(3'd1, 1'b0, 64'd12345, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b1);
    collect(0, 1'b0);
    do_req(3'd3, 1'b0, 64'd77, 64'd0, 5'd12, 64'd77, 3, 1'b1);
    collect(0, 1'b0);
    do_req(3'd0, 1'b1, 64'h1234_5678_0001_0000, 64'h8000, 5'd13, 64'hFFFF_FFFF_8000_0000, 35, 1'b1);
    collect(0, 1'b0);
    do_req(3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd4, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, 35, 1'b1);
    collect(0, 1'b0);
    do_req(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd15, 64'h7FFF_FFFF_FFFF_FFFF, 67, 1'b1);
    collect(0, 1'b0);
    do_req(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd16, 64'hFFFF_FFFF_FFFF_FFF2, 67, 1'b1);
    collect(0, 1'b0);
    do_req(3'd5, 1'b0, 64'd6, 64'd7, 5'd17, 64'd42, 67, 1'b1);
    collect(0, 1'b0);

    // Flush in RUN cycle 20, then a fresh request one cycle later.
    do_req(3'd0, 1'b0, 64'd3, 64'd4, 5'd18, 64'd0, 0, 1'b0);
    repeat (20) @(negedge clk);
    #1 check("run20_cnt", md_cnt, 20);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_ready", req_ready, 1);
    check("flush_valid", resp_valid, 0);
    check("flush_reseted", md_reseted, 0);
    do_req(3'd0, 1'b0, 64'd3, 64'd4, 5'd19, 64'd12, 67, 1'b1);
    collect(0, 1'b0);

    // Counter saturation with a core that never finishes.
    stall = 1'b1;
    do_req(3'd0, 1'b0, 64'd1, 64'd1, 5'd20, 64'd0, 0, 1'b0);
    repeat (140) @(negedge clk);
    #1;
    check("sat_cnt", md_cnt, 127);
    check("sat_valid", resp_valid, 0);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    #1 check("sat_flush_ready", req_ready, 1);

    // Flush coinciding with resp_ready in DONE: consumed once, nothing reissued.
    do_req(3'd2, 1'b1, 64'd100, 64'd7, 5'd21, 64'd14, 35, 1'b1);
    collect(0, 1'b1);
    @(negedge clk);
    #1 check("no_reissue", resp_valid, 0);

    // Flush beats a request in IDLE.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 3'd0; req_word = 1'b0; req_a = 64'hAAAA; req_b = 64'd1;
    #1 check("flush_req_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    #1;
    check("flush_req_idle", req_ready, 1);
    check("flush_req_md_A", md_A, {32'd100, 32'd0});

    // Reset mid-RUN returns every output to its reset value.
    do_req(3'd0, 1'b0, 64'd5, 64'd5, 5'd22, 64'd0, 0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("midrst_cnt", md_cnt, 0);
    check("midrst_reseted", md_reseted, 0);
    check("midrst_valid", resp_valid, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_md_A", md_A, 0);
    check("midrst_md_B", md_B, 0);
    check("midrst_data", resp_data, 0);
    check("midrst_rd", resp_rd, 0);
    reset = 1'b0;

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 req_valid / req_ready  in / out  1 / 1  request handshake from the execute issue logic.
REQ-005 req_op  in  3  operation code: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; codes 5-7 are treated as MUL.
REQ-006 req_word  in  1  32-bit (W) variant select.
REQ-007 req_a, req_b  in  64 each  source operands.
REQ-008 req_rd  in  5  destination tag, returned unchanged with the response.
REQ-009 flush  in  1  pipeline kill.
REQ-010 resp_valid / resp_ready  out / in  1 / 1  result handshake toward writeback.
REQ-011 resp_data / resp_rd  out  64 / 5  result value and result tag.
REQ-012 md_A, md_B  out  64 each  operands to the mul/div core.
REQ-013 md_sign, md_mul_div, md_width  out  1 each  core controls: signed; 0 = multiply, 1 = divide; 32-bit mode.
REQ-014 md_cnt  out  7  iteration counter driven to the core.
REQ-015 md_reseted  out  1  core control: 0 = load operands, 1 = iterate.
REQ-016 md_out, md_r  in  64 each  core product/quotient and remainder.
REQ-017 md_finished  in  1  core done flag; it may assert combinationally for trivial cases.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, RUN and DONE, encoded in 2 bits.
REQ-019 req_ready SHALL equal (state==IDLE && !flush).
REQ-020 On a cycle where req_valid and req_ready are both high, the block SHALL latch op, word, a, b and rd, and go IDLE->LOAD.
REQ-021 In LOAD, the block SHALL drive md_reseted=0 and md_cnt=0 for exactly one cycle, then go to RUN.
REQ-022 In RUN, md_reseted SHALL be 1 and md_cnt SHALL increment by 1 per cycle.
REQ-023 In RUN, the first cycle with md_finished=1 SHALL latch the result and go to DONE; md_cnt SHALL then stop and remain held.
REQ-024 md_cnt SHALL saturate at 127 and never wrap.
REQ-025 Core controls from the latched op: md_mul_div = op is DIV/DIVU/REM/REMU; md_sign = op is DIV or REM; md_width = word.
REQ-026 Operand placement, 64-bit mode: md_A=a and md_B=b.
REQ-027 Operand placement, word mode: md_A={a[31:0],32'b0} and md_B={b[31:0],32'b0}.
REQ-028 Result selection: MUL/DIV/DIVU take md_out; REM/REMU take md_r.
REQ-029 In word mode, the selected result SHALL be sign-extended from bit 31.
REQ-030 Latency from request handshake to resp_valid SHALL be 2+N cycles, where N is the number of RUN cycles up to and including the one where md_finished is seen.
- Full 64-bit operation: N=65.
- Word operation: N=33.
- Trivial-case early finish: N=1.
REQ-031 In DONE, resp_valid=1 and resp_data/resp_rd SHALL hold stable until resp_ready=1.
REQ-032 DONE SHALL exit to IDLE on resp_ready=1; no new request is accepted in that same cycle.
REQ-033 Outside DONE, resp_valid=0.
REQ-034 flush=1 in any state SHALL force IDLE on the next edge, discard any pending result, and keep resp_valid=0 from the next cycle.
REQ-035 If flush and req_valid are both high in IDLE, flush SHALL win and the request SHALL not be accepted.
REQ-036 If flush coincides with resp_ready in DONE, the response SHALL count as consumed, with no double issue.

Reset
REQ-037 reset=1 SHALL force state=IDLE, md_cnt=0, md_reseted=0 and resp_valid=0 on the next edge, and clear the result and tag registers to 0.
REQ-038 The reset values of req_ready (1 after reset), md_A and md_B (0) and resp_data (0) SHALL hold from the first cycle after reset.
REQ-039 reset SHALL take priority over flush and over every handshake, including a reset asserted mid-RUN.

Verification
REQ-040 MUL, a=7, b=-3, 64-bit -> resp_data=0xFFFF_FFFF_FFFF_FFEB, tag echoed, resp_valid 67 cycles after accept.
REQ-041 DIVU word, a=100, b=7 -> resp_data=14 after 35 cycles; REMU with the same operands -> 2.
REQ-042 DIV, b=0 -> md_finished in the first RUN cycle, resp_data=all ones, latency 3.
REQ-043 resp_ready held low 10 cycles in DONE -> resp_valid and resp_data stable throughout, one transfer only, req_ready high the cycle after the transfer.
REQ-044 flush at RUN cycle 20 -> IDLE next cycle, no response; a new request 1 cycle later completes correctly.
REQ-045 reset mid-RUN, and flush together with req_valid in IDLE -> all outputs at reset values / request not accepted.
